// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the shared single-port memory: grants one of fetch,
// load/store or external requesters, issues one memory cycle, waits out read latency, pulses done.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [1:0]    d_size,
  input  logic [31:0]   d_wdata,
  output logic          d_done,
  output logic          d_err,
  output logic [31:0]   d_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_done,
  output logic [31:0]   ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  localparam logic [1:0] OWN_IF = 2'd0, OWN_D = 2'd1, OWN_EXT = 2'd2;

  state_t        state, next_state;
  logic [1:0]    owner, win;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [1:0]    l_size;
  logic [31:0]   l_wdata;
  logic [3:0]    cnt;
  logic [31:0]   rdata_q;
  logic [7:0]    age;
  logic          any_req, ext_due, misalign;
  logic [1:0]    offset;
  logic [3:0]    be_base;

  assign any_req = if_req | d_req | ext_req;
  assign ext_due = ext_req && (age == 8'(MAX_WAIT));

  // A starved external requester overrides the fixed d > if > ext order.
  always_comb begin
    win = OWN_EXT;
    if (ext_due)     win = OWN_EXT;
    else if (d_req)  win = OWN_D;
    else if (if_req) win = OWN_IF;
  end

  // Byte accesses can never be misaligned; size 10 behaves as a word.
  assign misalign = (owner == OWN_D) &&
                    (((l_size == 2'b01) && l_addr[0]) ||
                     (l_size[1] && (l_addr[1:0] != 2'b00)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (any_req) next_state = ISSUE;
      ISSUE: next_state = (misalign || l_we) ? DONE : WAIT;
      WAIT:  if (cnt == 4'd1) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner   <= OWN_IF;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_size  <= 2'b00;
      l_wdata <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner <= win;
          case (win)
            OWN_D: begin
              l_we <= d_we; l_addr <= d_addr; l_size <= d_size; l_wdata <= d_wdata;
            end
            OWN_EXT: begin
              l_we <= ext_we; l_addr <= ext_addr; l_size <= 2'b11; l_wdata <= ext_wdata;
            end
            default: begin
              l_we <= 1'b0; l_addr <= if_addr; l_size <= 2'b11; l_wdata <= '0;
            end
          endcase
        end
        ISSUE: cnt <= 4'(RD_LAT);
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Age holds while ext owns the port and restarts whenever ext drops or wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                          age <= '0;
    else if (!ext_req)                                  age <= '0;
    else if (state == IDLE && any_req && win == OWN_EXT) age <= '0;
    else if (state != IDLE && owner == OWN_EXT)         age <= age;
    else if (age < 8'(MAX_WAIT))                        age <= age + 8'd1;
  end

  assign offset  = (owner == OWN_D) ? l_addr[1:0] : 2'b00;
  assign be_base = (l_size == 2'b00) ? 4'b0001 : (l_size == 2'b01) ? 4'b0011 : 4'b1111;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    if_done   = 1'b0;
    d_done    = 1'b0;
    ext_done  = 1'b0;
    d_err     = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    ext_rdata = '0;
    if (state == ISSUE && !misalign) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr[AW-1:2];
      mem_be    = be_base << offset;
      mem_wdata = l_wdata << {offset, 3'b000};
    end
    if (state == DONE) begin
      if_done  = (owner == OWN_IF);
      d_done   = (owner == OWN_D);
      ext_done = (owner == OWN_EXT);
      d_err    = d_done && misalign;
      if (if_done)                        if_rdata  = rdata_q;
      if (d_done && !l_we && !misalign)   d_rdata   = rdata_q;
      if (ext_done && !l_we)              ext_rdata = rdata_q;
    end
  end

  assign dbg_state = state;

endmodule
